sa_result_collector: RTL and testbench

Result-side consumer of the systolic-array controller's schedule. It follows the controller's `start`/`state_count`/`end_signal` timing, captures the skewed partial-sum outputs leaving the bottom of the N×N array, and deskews them into whole rows. It streams completed rows downstream over a valid/ready interface and raises `done` once the controller has finished and every row has been accepted. It sits between the array's bottom edge and the output buffer/writeback logic.

---
 rtl/sa_result_collector.sv | 163 ++++++++++++++++
 tb/tb_sa_result_collector.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sa_result_collector.sv
// -----------------------------------------------------------------------------
// sa_result_collector
//
// Result-side consumer of the systolic-array controller schedule. It samples
// the skewed partial sums leaving the bottom edge of the N x N array, deskews
// them into whole rows in a local buffer, and streams finished rows
// downstream over a valid/ready interface. `done` rises once the controller
// has finished and every row has been accepted.
//
// Ports
//   clk          rising-edge clock
//   rstn         synchronous active-low reset
//   start        controller enable (same signal that gates its counter)
//   state_count  controller schedule count
//   end_signal   controller completion flag (sticky until controller reset)
//   col_data     array bottom outputs, column j on [j*DW +: DW]
//   m_valid      a completed row is presented
//   m_ready      downstream accepts the presented row
//   m_data       presented row, column j on [j*DW +: DW]
//   m_row        index of the presented row
//   m_last       presented row is row N-1
//   done         run complete, all rows accepted
// -----------------------------------------------------------------------------
module sa_result_collector #(
    parameter int N  = 32,
    parameter int DW = 32,
    parameter int RW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [6:0]      state_count,
    input  logic            end_signal,
    input  logic [N*DW-1:0] col_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N*DW-1:0] m_data,
    output logic [RW-1:0]   m_row,
    output logic            m_last,
    output logic            done
);

    // Row pointers must reach N, so they carry one bit more than a row index.
    localparam int PW = RW + 1;

    localparam logic [6:0] FIN_LO = 7'(2 * N);
    localparam logic [6:0] FIN_HI = 7'(3 * N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rows_done;
    logic [PW-1:0]   rd_ptr_inc;
    logic            sample;
    logic            row_fin;
    logic            hs;
    logic            clear_cnt;

    // The controller advances its count on exactly these edges, so every
    // count value is seen once.
    assign sample  = start && !end_signal && (state == S_RUN);

    // The last column of row r lands at count 2N+r; that edge completes it.
    assign row_fin = sample && (state_count >= FIN_LO) && (state_count <= FIN_HI);

    assign hs         = m_valid && m_ready;
    assign rd_ptr_inc = rd_ptr + PW'(hs);
    assign clear_cnt  = (state == S_IDLE) || ((state == S_DONE) && !start);

    // -------------------------------------------------------------------------
    // Deskew buffer: one storage column per array column. Column j of count c
    // belongs to row c-(N+1)-j. Data is not reset; rows are always fully
    // rewritten before they are presented.
    // -------------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : gen_col
        localparam logic signed [8:0] OFS   = 9'(N + 1 + j);
        localparam logic signed [8:0] NROWS = 9'(N);

        logic signed [8:0] cap_row;
        logic              cap_ok;
        logic [DW-1:0]     col_buf [N];

        assign cap_row = $signed({2'b00, state_count}) - OFS;
        assign cap_ok  = sample && !cap_row[8] && (cap_row < NROWS);

        always_ff @(posedge clk) begin
            if (cap_ok) begin
                col_buf[cap_row[RW-1:0]] <= col_data[j*DW +: DW];
            end
        end

        // Gated so the stream reads zero whenever nothing is presented.
        assign m_data[j*DW +: DW] = m_valid ? col_buf[rd_ptr[RW-1:0]] : '0;
    end

    // -------------------------------------------------------------------------
    // Control: state register and row counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            rows_done <= '0;
        end else begin
            state <= state_nxt;
            if (clear_cnt) begin
                rd_ptr    <= '0;
                rows_done <= '0;
            end else begin
                if (hs) begin
                    rd_ptr <= rd_ptr_inc;
                end
                if (row_fin) begin
                    rows_done <= rows_done + PW'(1);
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && !end_signal && (state_count == 7'd0)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Count a handshake on this same edge when judging drain.
                if (end_signal) begin
                    state_nxt = (rd_ptr_inc == PW'(N)) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (hs && (rd_ptr == PW'(N - 1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output stream
    // -------------------------------------------------------------------------
    assign m_valid = (rd_ptr < rows_done) && ((state == S_RUN) || (state == S_FLUSH));
    assign m_row   = rd_ptr[RW-1:0];
    assign m_last  = m_valid && (rd_ptr == PW'(N - 1));
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_sa_result_collector.sv
// -----------------------------------------------------------------------------
// tb_sa_result_collector
//
// Drives the collector with a behavioural model of the array controller and
// checks every cycle against a row-level reference: rows become ready as the
// controller count passes 2N+r, are consumed in order on handshakes, and
// row r word j carries salt ^ ((r<<8)|j).
// -----------------------------------------------------------------------------
module tb_sa_result_collector;

    localparam int N  = 32;
    localparam int DW = 32;
    localparam int RW = $clog2(N);

    logic            clk;
    logic            rstn;
    logic            start;
    logic [6:0]      state_count;
    logic            end_signal;
    logic [N*DW-1:0] col_data;
    logic            m_valid;
    logic            m_ready;
    logic [N*DW-1:0] m_data;
    logic [RW-1:0]   m_row;
    logic            m_last;
    logic            done;

    sa_result_collector #(.N(N), .DW(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .state_count (state_count),
        .end_signal  (end_signal),
        .col_data    (col_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_row       (m_row),
        .m_last      (m_last),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 run, 2 flush, 3 done.
    int            ph    = 0;
    int            ready = 0;
    int            cons  = 0;
    int            ccnt  = 0;
    bit            cend  = 1'b0;
    logic [DW-1:0] salt  = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, check the outputs left by
    // the previous rising edge, then advance model and controller.
    task automatic cycle(input bit rn, input bit st, input bit rdy, input bit clr, input bit rnd);
        logic [6:0] sc;
        logic       es;
        int         r;
        bit         exp_v;
        bit         hs;
        if (rnd) begin
            sc = 7'($urandom);
            es = 1'($urandom);
        end else begin
            sc = 7'(ccnt);
            es = cend;
        end
        for (int j = 0; j < N; j++) begin
            r = int'(sc) - (N + 1) - j;
            if (!rnd && r >= 0 && r < N)
                col_data[j*DW +: DW] = salt ^ DW'((r << 8) | j);
            else
                col_data[j*DW +: DW] = $urandom;
        end
        rstn        = rn;
        start       = st;
        m_ready     = rdy;
        state_count = sc;
        end_signal  = es;

        exp_v = (ph == 1 || ph == 2) && (cons < ready);
        chk("m_valid", 64'(m_valid), 64'(exp_v));
        chk("done", 64'(done), 64'(ph == 3));
        chk("m_last", 64'(m_last), 64'(exp_v && cons == N - 1));
        if (exp_v) begin
            chk("m_row", 64'(m_row), 64'(cons));
            for (int j = 0; j < N; j++)
                chk("m_data", 64'(m_data[j*DW +: DW]), 64'(salt ^ DW'((cons << 8) | j)));
        end
        if (ph == 0) begin
            chk("m_row_idle", 64'(m_row), 64'(0));
            chk("m_data_idle", 64'(|m_data), 64'(0));
        end

        hs = exp_v && rdy;
        if (!rn) begin
            ph = 0; ready = 0; cons = 0;
        end else begin
            case (ph)
                0: if (st && !es && sc == 0) ph = 1;
                1: begin
                    if (st && !es && int'(sc) >= 2 * N)
                        ready = (int'(sc) - 2 * N + 1 > N) ? N : int'(sc) - 2 * N + 1;
                    if (hs) cons++;
                    if (es) ph = (cons == N) ? 3 : 2;
                end
                2: begin
                    if (hs) cons++;
                    if (cons == N) ph = 3;
                end
                default: if (!st) begin ph = 0; ready = 0; cons = 0; end
            endcase
        end

        if (clr) begin
            ccnt = 0;
            cend = 1'b0;
        end else if (st && !cend) begin
            if (ccnt == 3 * N + 1) cend = 1'b1;
            else ccnt++;
        end
        @(negedge clk);
    endtask

    // mode 0: m_ready held high, 1: low until end_signal, 2: random.
    task automatic run_one(input int mode, input int pause_at, input int reset_at);
        int  pause_left = 0;
        bit  paused     = 1'b0;
        bit  st;
        bit  rdy;
        salt = $urandom;
        for (int k = 0; k < 600 && ph != 3; k++) begin
            if (reset_at >= 0 && ccnt == reset_at) begin
                cycle(0, 1, 1, 1, 1);
                cycle(0, 1, 1, 1, 1);
                return;
            end
            if (pause_at >= 0 && ccnt == pause_at && !paused) begin
                paused     = 1'b1;
                pause_left = 10;
            end
            st = (pause_left == 0);
            if (pause_left > 0) pause_left--;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cend;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            cycle(1, st, rdy, 0, 0);
        end
        chk("run_reaches_done", 64'(ph), 64'(3));
        cycle(1, 1, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 1, 1, 0);
    endtask

    initial begin
        rstn        = 1'b0;
        start       = 1'b0;
        m_ready     = 1'b0;
        state_count = '0;
        end_signal  = 1'b0;
        col_data    = '0;
        @(negedge clk);

        // Reset with random inputs, then confirm IDLE waits for count 0.
        for (int i = 0; i < 3; i++)
            cycle(0, 1'($urandom), 1'($urandom), 1, 1);
        ccnt = 7;
        for (int i = 0; i < 3; i++)
            cycle(1, 1, 1, 0, 0);
        cycle(1, 0, 1, 1, 0);

        run_one(0, -1, -1);   // full throughput
        run_one(1, -1, -1);   // full backpressure, drains in FLUSH
        run_one(2, -1, -1);   // random backpressure
        run_one(0, 70, -1);   // controller pause
        run_one(2, -1, 80);   // reset mid-run
        run_one(2, -1, -1);   // fresh run after reset
        run_one(0, -1, -1);   // re-run after DONE

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
